// File: rtl/prover_shuffle_v_core.sv
// prover_shuffle_v_core
// Holds the prover's 2^nInBits array of field elements between sumcheck
// rounds. Each step applies a perfect unshuffle: even-indexed elements go to
// the lower half, odd-indexed to the upper half. A load replaces the array
// with v_in. Results land after plstages cycles and are flagged by
// ready_pulse.
//
// Ports:
//   clk          rising-edge clock
//   rstb         synchronous active-high reset
//   en           start one operation (step, or load when restart=1)
//   restart      qualifies en as a load; accepted even while busy (aborts)
//   v_in         array loaded on restart
//   ready        idle and able to accept en
//   ready_pulse  one-cycle strobe on the cycle a result appears
//   v_out        current array
//
// Element width comes from the F_NBITS macro (64 when undefined).
// Optional macro PROVER_SHUFFLE_V_ASSERT_EN adds simulation-only protocol checks.

`ifndef F_NBITS
`define F_NBITS 64
`endif

module prover_shuffle_v_core #(
  parameter int unsigned nInBits  = 4,
  parameter int unsigned plstages = 2,
  localparam int unsigned FW = `F_NBITS,
  localparam int unsigned NG = 1 << nInBits
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          en,
  input  logic          restart,
  input  logic [FW-1:0] v_in  [NG],
  output logic          ready,
  output logic          ready_pulse,
  output logic [FW-1:0] v_out [NG]
);

  localparam int unsigned CW = $clog2(plstages + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] res_q  [NG];
  logic [FW-1:0] step_c [NG];
  logic          accept_c;

  // A restart is honoured regardless of busy state; a plain step needs ready.
  assign accept_c = en & (ready | restart);

  // Unshuffle as a gather: result[j] = v_out[rotate-left(j, 1)].
  for (genvar j = 0; j < NG; j++) begin : g_perm
    localparam int unsigned SRC = ((j << 1) | (j >> (nInBits - 1))) & (NG - 1);
    assign step_c[j] = v_out[SRC];
  end

  // Result is captured at acceptance; v_out only moves on completion, so the
  // step operand is v_out as of the acceptance edge.
  always_ff @(posedge clk) begin
    ready_pulse <= 1'b0;
    if (rstb) begin
      state <= S_IDLE;
      ready <= 1'b1;
      cnt   <= '0;
      for (int i = 0; i < NG; i++) begin
        v_out[i] <= '0;
        res_q[i] <= '0;
      end
    end else if (accept_c) begin
      // Also covers restart while busy: the in-flight result is overwritten.
      state <= S_BUSY;
      ready <= 1'b0;
      cnt   <= CW'(plstages);
      for (int i = 0; i < NG; i++) begin
        res_q[i] <= restart ? v_in[i] : step_c[i];
      end
    end else if (state == S_BUSY) begin
      if (cnt == CW'(1)) begin
        state       <= S_IDLE;
        ready       <= 1'b1;
        ready_pulse <= 1'b1;
        for (int i = 0; i < NG; i++) begin
          v_out[i] <= res_q[i];
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef PROVER_SHUFFLE_V_ASSERT_EN
  logic pulse_d;

  always_ff @(posedge clk) begin
    pulse_d <= rstb ? 1'b0 : ready_pulse;
  end

  always @(posedge clk) begin
    if (!rstb) begin
      if (en && !restart && !ready)
        $error("prover_shuffle_v_core: en without restart while busy is ignored");
      if (ready_pulse && pulse_d)
        $error("prover_shuffle_v_core: ready_pulse high for two consecutive cycles");
      if (ready_pulse && !ready)
        $error("prover_shuffle_v_core: ready_pulse asserted while ready is low");
    end
  end
`endif

endmodule

// File: tb/tb_prover_shuffle_v_core.sv
// Scoreboard bench for prover_shuffle_v_core (nInBits=4, plstages=2, 64-bit).
module tb_prover_shuffle_v_core;

  localparam int NB = 4;
  localparam int PL = 2;
  localparam int NG = 1 << NB;
  localparam int FW = 64;

  typedef logic [NG*FW-1:0] flat_t;

  logic          clk;
  logic          rstb;
  logic          en;
  logic          en_drv;
  logic          chain_on;
  logic          restart;
  logic [FW-1:0] v_in  [NG];
  logic          ready;
  logic          ready_pulse;
  logic [FW-1:0] v_out [NG];

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  flat_t exp_q[$];
  int    cyc_q[$];

  // Chained mode re-issues en on the cycle after each completion.
  assign en = en_drv | (chain_on & ready_pulse);

  prover_shuffle_v_core #(.nInBits(NB), .plstages(PL)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .en         (en),
    .restart    (restart),
    .v_in       (v_in),
    .ready      (ready),
    .ready_pulse(ready_pulse),
    .v_out      (v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic flat_t pack_vout();
    flat_t f;
    for (int i = 0; i < NG; i++) f[i*FW +: FW] = v_out[i];
    return f;
  endfunction

  function automatic flat_t mk_ident(input int base);
    flat_t f;
    for (int i = 0; i < NG; i++) f[i*FW +: FW] = FW'(base + i);
    return f;
  endfunction

  // One unshuffle from identity: 0,2,..,14,1,3,..,15
  function automatic flat_t mk_s1();
    flat_t f;
    for (int i = 0; i < NG; i++)
      f[i*FW +: FW] = (i < NG/2) ? FW'(2*i) : FW'(2*(i - NG/2) + 1);
    return f;
  endfunction

  // Two unshuffles from identity: 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15
  function automatic flat_t mk_s2();
    flat_t f;
    for (int i = 0; i < NG; i++) f[i*FW +: FW] = FW'(4*(i % 4) + i / 4);
    return f;
  endfunction

  // Scatter form: new[(i>>1) + (i&1)*NG/2] = old[i]
  function automatic flat_t shuf(input flat_t o);
    flat_t f;
    for (int i = 0; i < NG; i++) f[((i >> 1) + (i & 1) * (NG/2))*FW +: FW] = o[i*FW +: FW];
    return f;
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_arr(input string name, input flat_t act, input flat_t req);
    int idx;
    checks++;
    if (act !== req) begin
      errors++;
      idx = 0;
      for (int i = NG - 1; i >= 0; i--)
        if (act[i*FW +: FW] !== req[i*FW +: FW]) idx = i;
      $display("FAIL %s: element %0d actual=%0h required=%0h (cycle %0d)",
               name, idx, act[idx*FW +: FW], req[idx*FW +: FW], cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_vin(input int base);
    for (int i = 0; i < NG; i++) v_in[i] = FW'(base + i);
  endtask

  task automatic expect_at(input flat_t d, input int c);
    exp_q.push_back(d);
    cyc_q.push_back(c);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (ready && exp_q.size() == 0) done = 1'b1;
      else tick();
    end
    check_eq("idle_timeout", 64'(done), 64'd1);
  endtask

  // Issue one op for one edge; ready must be low for the next PL edges.
  task automatic do_op(input logic rs, input flat_t req);
    en_drv  = 1'b1;
    restart = rs;
    expect_at(req, cyc + 1 + PL);
    tick();
    en_drv  = 1'b0;
    restart = 1'b0;
    check_eq("busy_ready", 64'(ready), 64'd0);
    for (int i = 1; i < PL; i++) begin
      tick();
      check_eq("busy_ready", 64'(ready), 64'd0);
    end
    wait_idle();
  endtask

  task automatic monitor();
    flat_t d;
    int    c;
    forever begin
      @(negedge clk);
      if (!rstb && ready_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          d = exp_q.pop_front();
          c = cyc_q.pop_front();
          check_arr("pulse_data", pack_vout(), d);
          check_eq("pulse_cycle", 64'(cyc), 64'(c));
          check_eq("ready_at_pulse", 64'(ready), 64'd1);
        end
      end
    end
  endtask

  initial begin
    int   pulses;
    flat_t s2;
    rstb     = 1'b1;
    en_drv   = 1'b0;
    chain_on = 1'b0;
    restart  = 1'b0;
    set_vin(0);
    s2 = mk_s2();
    fork
      monitor();
    join_none

    // 1: reset state
    tick();
    check_arr("reset_vout", pack_vout(), '0);
    check_eq("reset_ready", 64'(ready), 64'd1);
    check_eq("reset_pulse", 64'(ready_pulse), 64'd0);
    rstb = 1'b0;
    tick();

    // 2: load identity
    set_vin(0);
    do_op(1'b1, mk_ident(0));

    // 3: single step
    do_op(1'b0, mk_s1());

    // 4: reload identity, then four chained steps
    do_op(1'b1, mk_ident(0));
    expect_at(mk_s1(),        cyc + 1 + PL);
    expect_at(s2,             cyc + 1 + 2*PL + 1);
    expect_at(shuf(s2),       cyc + 1 + 3*PL + 2);
    expect_at(mk_ident(0),    cyc + 1 + 4*PL + 3);
    en_drv = 1'b1;
    tick();
    en_drv   = 1'b0;
    chain_on = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 4; i++) begin
      tick();
      if (ready_pulse) pulses++;
    end
    chain_on = 1'b0;
    check_eq("chain_pulses", 64'(pulses), 64'd4);
    wait_idle();

    // 5: restart one cycle after a step was accepted
    en_drv  = 1'b1;
    restart = 1'b0;
    tick();
    restart = 1'b1;
    set_vin(100);
    expect_at(mk_ident(100), cyc + 1 + PL);
    tick();
    en_drv  = 1'b0;
    restart = 1'b0;
    wait_idle();
    repeat (4) tick();

    // 6a: reset while busy discards the operation
    en_drv = 1'b1;
    tick();
    en_drv = 1'b0;
    check_eq("pre_reset_busy", 64'(ready), 64'd0);
    rstb = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    tick();
    rstb = 1'b0;
    check_arr("midop_reset_vout", pack_vout(), '0);
    check_eq("midop_reset_ready", 64'(ready), 64'd1);
    check_eq("midop_reset_pulse", 64'(ready_pulse), 64'd0);
    repeat (5) tick();

    // 6b: en without restart while busy is ignored
    set_vin(0);
    do_op(1'b1, mk_ident(0));
    en_drv = 1'b1;
    expect_at(mk_s1(), cyc + 1 + PL);
    tick();
    check_eq("ignored_en_busy", 64'(ready), 64'd0);
    tick();
    en_drv = 1'b0;
    wait_idle();
    repeat (6) tick();
    check_eq("leftover_expect", 64'(exp_q.size()), 64'd0);
    check_arr("final_vout", pack_vout(), mk_s1());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
